// File: rtl/interrupt_controller_if.sv
// Register bus and CPU acknowledge handshake shared by the interrupt
// controller and the CPU side.
interface interrupt_controller_if #(
    parameter int ID_W = 3
);
    logic            we;
    logic [1:0]      addr;
    logic [31:0]     din;
    logic [31:0]     dout;
    logic            intr;
    logic            inta;
    logic [ID_W-1:0] int_id;

    modport master (
        output we, addr, din, inta,
        input  dout, intr, int_id
    );

    modport slave (
        input  we, addr, din, inta,
        output dout, intr, int_id
    );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: latches edge/level requests into PEND,
// masks them, picks the lowest-index winner and runs the intr/inta/EOI
// handshake with the CPU.
module interrupt_controller #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [N_SRC-1:0]     irq_in,
    interrupt_controller_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t          state;
    logic            intr_reg;
    logic [ID_W-1:0] id_reg;

    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edge_mode;
    logic [N_SRC-1:0] irq_prev;

    logic [N_SRC-1:0] din_src;
    logic [N_SRC-1:0] act;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] edge_chg;
    logic [N_SRC-1:0] ack_clr;
    logic [ID_W-1:0]  winner;
    logic             act_any;
    logic             ack;
    logic             eoi;
    logic [31:0]      rdata;

    assign din_src = bus.din[N_SRC-1:0];
    assign act     = pend & mask;
    assign act_any = |act;
    assign rise    = irq_in & ~irq_prev;
    assign ack     = (state == REQ) && bus.inta && act_any;
    assign eoi     = bus.we && (bus.addr == 2'd3);

    if (N_SRC < 32) begin : g_unused_din
        logic unused_din;
        assign unused_din = ^bus.din[31:N_SRC];
    end

    // Lowest-index active source wins; scan downwards so index 0 overrides.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) winner = ID_W'(i);
        end
    end

    // Per-source clear/flush masks derived from this cycle's bus write and acknowledge.
    always_comb begin
        w1c      = '0;
        edge_chg = '0;
        ack_clr  = '0;
        if (bus.we && bus.addr == 2'd0) w1c = din_src & edge_mode;
        if (bus.we && bus.addr == 2'd2) edge_chg = din_src ^ edge_mode;
        if (ack) ack_clr[winner] = 1'b1;
    end

    // Request sampling, pending latch (set beats clear in edge mode) and config registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            irq_prev  <= '0;
            pend      <= '0;
            mask      <= '0;
            edge_mode <= '0;
        end else begin
            irq_prev <= irq_in;
            pend     <= ((edge_mode & (rise | (pend & ~(w1c | ack_clr))))
                        | (~edge_mode & irq_in)) & ~edge_chg;
            if (bus.we && bus.addr == 2'd1) mask <= din_src;
            if (bus.we && bus.addr == 2'd2) edge_mode <= din_src;
        end
    end

    // Handshake FSM: raise intr, take the winner on inta, wait for EOI (no nesting).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            intr_reg <= 1'b0;
            id_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (act_any) begin
                        state    <= REQ;
                        intr_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.inta && act_any) begin
                        id_reg   <= winner;
                        intr_reg <= 1'b0;
                        state    <= SERV;
                    end else if (!act_any) begin
                        intr_reg <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        intr_reg <= 1'b1;
                    end
                end
                SERV: begin
                    intr_reg <= 1'b0;
                    if (eoi) state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    intr_reg <= 1'b0;
                end
            endcase
        end
    end

    // Combinational register read mux; unused upper bits read zero.
    always_comb begin
        rdata = '0;
        case (bus.addr)
            2'd0: rdata[N_SRC-1:0] = pend;
            2'd1: rdata[N_SRC-1:0] = mask;
            2'd2: rdata[N_SRC-1:0] = edge_mode;
            2'd3: begin
                rdata[ID_W-1:0] = id_reg;
                rdata[31]       = (state == SERV);
            end
            default: rdata = '0;
        endcase
    end

    assign bus.dout   = rdata;
    assign bus.intr   = intr_reg;
    assign bus.int_id = id_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

    localparam int N_SRC = 8;
    localparam int ID_W  = 3;

    logic             clk = 1'b0;
    logic             clrn;
    logic [N_SRC-1:0] irq_in;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_controller_if #(.ID_W(ID_W)) bus ();

    interrupt_controller #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk    (clk),
        .clrn   (clrn),
        .irq_in (irq_in),
        .bus    (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.dout;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] expected);
        logic [31:0] v;
        readReg(a, v);
        checkOutput(tag, v, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.din  = d;
        tick();
        bus.we   = 1'b0;
    endtask

    task automatic ackPulse(input int cycles);
        bus.inta = 1'b1;
        repeat (cycles) tick();
        bus.inta = 1'b0;
    endtask

    initial begin
        clrn     = 1'b0;
        irq_in   = '0;
        bus.we   = 1'b0;
        bus.addr = 2'd0;
        bus.din  = '0;
        bus.inta = 1'b0;
        repeat (3) tick();

        // Reset state
        checkOutput("rst_intr", {31'b0, bus.intr}, 32'h0);
        checkOutput("rst_id", {29'b0, bus.int_id}, 32'h0);
        checkReg("rst_pend", 2'd0, 32'h0);
        checkReg("rst_stat", 2'd3, 32'h0);
        clrn = 1'b1;
        tick();

        // Single edge request on source 3
        applyStimulus(2'd1, 32'hFF);
        applyStimulus(2'd2, 32'hFF);
        checkReg("mask_rd", 2'd1, 32'hFF);
        checkReg("edge_rd", 2'd2, 32'hFF);
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        checkReg("t1_pend", 2'd0, 32'h08);
        checkOutput("t1_intr_lat1", {31'b0, bus.intr}, 32'h0);
        tick();
        checkOutput("t1_intr_lat2", {31'b0, bus.intr}, 32'h1);
        ackPulse(1);
        checkOutput("t1_id", {29'b0, bus.int_id}, 32'h3);
        checkOutput("t1_intr_ack", {31'b0, bus.intr}, 32'h0);
        checkReg("t1_pend_ack", 2'd0, 32'h00);
        checkReg("t1_stat", 2'd3, 32'h80000003);
        applyStimulus(2'd3, 32'h0);
        checkReg("t1_stat_eoi", 2'd3, 32'h00000003);
        tick();
        checkOutput("t1_intr_idle", {31'b0, bus.intr}, 32'h0);

        // Two simultaneous edges: priority, then the loser after EOI
        irq_in = 8'h24;
        tick();
        irq_in = 8'h00;
        tick();
        checkOutput("t2_intr", {31'b0, bus.intr}, 32'h1);
        ackPulse(2);
        checkOutput("t2_id", {29'b0, bus.int_id}, 32'h2);
        checkReg("t2_pend", 2'd0, 32'h20);
        checkOutput("t2_intr_serv", {31'b0, bus.intr}, 32'h0);
        applyStimulus(2'd3, 32'h0);
        checkOutput("t2_intr_eoi", {31'b0, bus.intr}, 32'h0);
        tick();
        checkOutput("t2_intr_re", {31'b0, bus.intr}, 32'h1);
        ackPulse(1);
        checkOutput("t2_id2", {29'b0, bus.int_id}, 32'h5);
        checkReg("t2_pend2", 2'd0, 32'h00);
        applyStimulus(2'd3, 32'h0);

        // Level-mode source 1
        applyStimulus(2'd2, 32'hFD);
        irq_in = 8'h02;
        tick();
        checkReg("t3_pend", 2'd0, 32'h02);
        tick();
        checkOutput("t3_intr", {31'b0, bus.intr}, 32'h1);
        ackPulse(1);
        checkOutput("t3_id", {29'b0, bus.int_id}, 32'h1);
        checkReg("t3_pend_ack", 2'd0, 32'h02);
        applyStimulus(2'd3, 32'h0);
        tick();
        checkOutput("t3_intr_re", {31'b0, bus.intr}, 32'h1);
        irq_in = 8'h00;
        repeat (3) tick();
        checkReg("t3_pend_drop", 2'd0, 32'h00);
        checkOutput("t3_intr_drop", {31'b0, bus.intr}, 32'h0);
        applyStimulus(2'd2, 32'hFF);

        // Masking while in REQ
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        checkOutput("t4_intr", {31'b0, bus.intr}, 32'h1);
        applyStimulus(2'd1, 32'h00);
        tick();
        checkOutput("t4_intr_mask", {31'b0, bus.intr}, 32'h0);
        ackPulse(1);
        checkOutput("t4_intr_ign", {31'b0, bus.intr}, 32'h0);
        checkReg("t4_stat_ign", 2'd3, 32'h00000001);
        checkReg("t4_pend", 2'd0, 32'h10);
        applyStimulus(2'd1, 32'h10);
        tick();
        checkOutput("t4_intr_back", {31'b0, bus.intr}, 32'h1);
        ackPulse(1);
        checkOutput("t4_id", {29'b0, bus.int_id}, 32'h4);
        applyStimulus(2'd3, 32'h0);
        applyStimulus(2'd1, 32'hFF);

        // Edge and W1C in the same cycle: set wins
        irq_in = 8'h40;
        applyStimulus(2'd0, 32'h40);
        irq_in = 8'h00;
        checkReg("t5_pend", 2'd0, 32'h40);
        tick();
        checkOutput("t5_intr", {31'b0, bus.intr}, 32'h1);
        ackPulse(1);
        checkOutput("t5_id", {29'b0, bus.int_id}, 32'h6);

        // Asynchronous reset in SERV
        irq_in = 8'h0C;
        tick();
        irq_in = 8'h01;
        checkReg("t6_pend", 2'd0, 32'h0C);
        checkReg("t6_stat", 2'd3, 32'h80000006);
        #1;
        clrn = 1'b0;
        #1;
        checkOutput("t6_rst_intr", {31'b0, bus.intr}, 32'h0);
        checkOutput("t6_rst_id", {29'b0, bus.int_id}, 32'h0);
        checkReg("t6_rst_pend", 2'd0, 32'h0);
        checkReg("t6_rst_mask", 2'd1, 32'h0);
        checkReg("t6_rst_edge", 2'd2, 32'h0);
        checkReg("t6_rst_stat", 2'd3, 32'h0);
        tick();
        clrn = 1'b1;
        applyStimulus(2'd2, 32'hFF);
        applyStimulus(2'd1, 32'hFF);
        tick();
        tick();
        checkReg("t6_held_pend", 2'd0, 32'h00);
        checkOutput("t6_held_intr", {31'b0, bus.intr}, 32'h0);
        irq_in = 8'h00;
        tick();
        irq_in = 8'h01;
        tick();
        checkReg("t6_tog_pend", 2'd0, 32'h01);
        tick();
        checkOutput("t6_tog_intr", {31'b0, bus.intr}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Prioritised interrupt controller that sits directly upstream of the pipelined CPU's interrupt input. It collects up to `N_SRC` external request lines, each configurable as edge- or level-triggered, and latches them into a pending register. It masks and prioritises the pending requests, then drives the CPU's `intr` and completes the `inta` acknowledge handshake. The CPU reads the winning source ID and signals end-of-interrupt through a small memory-mapped register port.

## Interface
Parameters:
- `N_SRC`, 8: number of interrupt sources, 2..32.
- `ID_W`, 3: width of the source ID, equal to clog2(`N_SRC`).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `clrn`  in  1: reset, asynchronous and active-low.
- `irq_in`  in  `N_SRC`: request lines, synchronous to `clk`.
- `we`  in  1: register write strobe.
- `addr`  in  2: register select.
- `din`  in  32: write data.
- `dout`  out  32: read data, combinational from `addr`; bits above `N_SRC` read 0.
- `intr`  out  1: interrupt request to the CPU, registered.
- `inta`  in  1: acknowledge from the CPU, sampled on `clk`.
- `int_id`  out  `ID_W`: ID of the interrupt being serviced, registered.

## Operation
Register map:
- addr 0 PEND:
  - Read returns the pending bits.
  - Write-1-to-clear, edge-mode bits only.
  - Level-mode bits ignore the write.
- addr 1 MASK: read/write; 1 = source enabled.
- addr 2 EDGE: read/write; 1 = edge-triggered, 0 = level-triggered.
- addr 3 STAT:
  - Read returns {`int_id` in bits [ID_W-1:0], in-service flag in bit 31}.
  - Any write is EOI (end of interrupt).

Pending logic:
- `irq_prev` is a registered copy of `irq_in`.
- Edge mode: `pend[i]` sets when `irq_in[i]` & ~`irq_prev[i]`. It clears on W1C or on acknowledge of source i.
- Edge mode, simultaneous set and clear: set wins.
- Level mode: `pend[i]` <= `irq_in[i]` every cycle. It is not cleared by W1C or acknowledge; the source must deassert.
- Changing EDGE[i] clears `pend[i]` on that write.

Priority: `act` = PEND & MASK. The winner is the lowest-index set bit of `act`; source 0 has the highest priority.

State machine (IDLE, REQ, SERV):
- IDLE:
  - If `act` != 0, go to REQ and set `intr`=1.
  - `inta` is ignored.
- REQ:
  - If `inta`=1 and `act` != 0: latch `int_id` = winner evaluated in that same cycle, clear the winner's pending bit if it is edge-mode, set `intr`=0, go to SERV.
  - Else if `act`=0 (masked or cleared meanwhile): set `intr`=0, go to IDLE.
  - Else hold `intr`=1.
- SERV:
  - `intr`=0; no nesting. New requests keep accumulating in PEND.
  - An EOI write goes to IDLE. The next request may then raise `intr` on the following cycle.
- An EOI write outside SERV is ignored.
- `inta` outside REQ is ignored.

Reset (`clrn`=0), asynchronous and effective at any state, including mid-handshake:
- PEND, MASK, EDGE, `irq_prev` = 0.
- State = IDLE, `intr`=0, `int_id`=0.
- `dout` reads 0 at every address.

## Timing
- `irq_in[i]` first sampled high at edge k (edge mode, enabled): `pend[i]`=1 after edge k, `intr`=1 after edge k+1. Request-to-`intr` latency is 2 cycles.
- `inta` sampled high at edge m in REQ: `intr`=0, `int_id` valid and the pending bit cleared, all after edge m.
- `inta` may be a 1-cycle pulse or longer. Extra cycles of `inta` in SERV have no effect.
- Register writes take effect after the edge where `we`=1. Reads are same-cycle combinational.
- EOI at edge n with `act` != 0: IDLE after edge n, `intr`=1 after edge n+1.

## Test plan
- Reset, MASK=0xFF, EDGE=0xFF, then pulse `irq_in[3]` for 1 cycle -> `intr`=1 two cycles later. Pulse `inta` -> `int_id`=3, PEND=0x00, STAT reads 0x80000003. EOI -> IDLE, `intr` stays 0.
- Edge mode, `irq_in[5]` and `irq_in[2]` rise together -> `inta` gives `int_id`=2 and PEND=0x20. EOI -> `intr` re-asserts one cycle later, next `inta` gives `int_id`=5.
- Level mode on source 1, held high -> acknowledge gives `int_id`=1 and PEND still 0x02. After EOI `intr` re-asserts. Drop `irq_in[1]` -> PEND=0x00, no further `intr`.
- Pending source 4 in REQ, write MASK=0x00 before `inta` -> `intr` falls the next cycle and a later `inta` is ignored. Write MASK=0x10 -> `intr` returns.
- Edge on source 6 in the same cycle as a W1C write of 0x40 to PEND -> PEND bit 6 stays 1.
- Drive `clrn` low during SERV with PEND=0x0C -> `intr`=0, `int_id`=0, all registers read 0 immediately. After release, `irq_in` held high produces no edge until it toggles.
